// File: rtl/pipe_wb_if.sv
// Per-instruction bundle handed from the MEM stage to the MEM/WB latch.
// The MEM stage drives through the master modport; write-back samples through the slave modport.
interface pipe_wb_if;
   logic        mem_valid;
   logic [31:0] mem_mul_hi;
   logic [31:0] mem_mul_lo;
   logic [31:0] mem_div_r;
   logic [31:0] mem_div_q;
   logic [31:0] mem_clz_out;
   logic [31:0] mem_alu_out;
   logic [31:0] mem_dmem_out;
   logic [31:0] mem_pc4;
   logic [31:0] mem_rs_data_out;
   logic [31:0] mem_cp0_out;
   logic [4:0]  mem_rf_waddr;
   logic        mem_rf_wena;
   logic        mem_hi_wena;
   logic        mem_lo_wena;
   logic [1:0]  mem_hi_mux_sel;
   logic [1:0]  mem_lo_mux_sel;
   logic [2:0]  mem_rf_mux_sel;

   modport master (
      output mem_valid, mem_mul_hi, mem_mul_lo, mem_div_r, mem_div_q, mem_clz_out,
             mem_alu_out, mem_dmem_out, mem_pc4, mem_rs_data_out, mem_cp0_out,
             mem_rf_waddr, mem_rf_wena, mem_hi_wena, mem_lo_wena,
             mem_hi_mux_sel, mem_lo_mux_sel, mem_rf_mux_sel
   );

   modport slave (
      input  mem_valid, mem_mul_hi, mem_mul_lo, mem_div_r, mem_div_q, mem_clz_out,
             mem_alu_out, mem_dmem_out, mem_pc4, mem_rs_data_out, mem_cp0_out,
             mem_rf_waddr, mem_rf_wena, mem_hi_wena, mem_lo_wena,
             mem_hi_mux_sel, mem_lo_mux_sel, mem_rf_mux_sel
   );
endinterface

// File: rtl/pipe_wb.sv
// MEM/WB pipeline latch and write-back stage: RF write-data select, architectural HI/LO,
// HI/LO forwarding and a retired-instruction counter.
module pipe_wb #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             flush,
   pipe_wb_if.slave         mem,
   output logic             rf_wena,
   output logic [4:0]       rf_waddr,
   output logic [31:0]      rf_wdata,
   output logic [31:0]      hi_out,
   output logic [31:0]      lo_out,
   output logic [31:0]      hi_fwd,
   output logic [31:0]      lo_fwd,
   output logic             wb_valid,
   output logic [CNT_W-1:0] instret
);

   typedef struct packed {
      logic        valid;
      logic        rf_wena;
      logic        hi_wena;
      logic        lo_wena;
      logic [1:0]  hi_sel;
      logic [1:0]  lo_sel;
      logic [2:0]  rf_sel;
      logic [4:0]  waddr;
      logic [31:0] mul_hi;
      logic [31:0] mul_lo;
      logic [31:0] div_r;
      logic [31:0] div_q;
      logic [31:0] clz;
      logic [31:0] alu;
      logic [31:0] dmem;
      logic [31:0] pc4;
      logic [31:0] rs;
      logic [31:0] cp0;
   } slot_t;

   slot_t             slot_d;
   slot_t             slot_q;
   logic [31:0]       hi_q;
   logic [31:0]       lo_q;
   logic [31:0]       hi_next;
   logic [31:0]       lo_next;
   logic [CNT_W-1:0]  cnt_q;
   logic              retire;

   always_comb begin
      slot_d.valid   = mem.mem_valid;
      slot_d.rf_wena = mem.mem_rf_wena;
      slot_d.hi_wena = mem.mem_hi_wena;
      slot_d.lo_wena = mem.mem_lo_wena;
      slot_d.hi_sel  = mem.mem_hi_mux_sel;
      slot_d.lo_sel  = mem.mem_lo_mux_sel;
      slot_d.rf_sel  = mem.mem_rf_mux_sel;
      slot_d.waddr   = mem.mem_rf_waddr;
      slot_d.mul_hi  = mem.mem_mul_hi;
      slot_d.mul_lo  = mem.mem_mul_lo;
      slot_d.div_r   = mem.mem_div_r;
      slot_d.div_q   = mem.mem_div_q;
      slot_d.clz     = mem.mem_clz_out;
      slot_d.alu     = mem.mem_alu_out;
      slot_d.dmem    = mem.mem_dmem_out;
      slot_d.pc4     = mem.mem_pc4;
      slot_d.rs      = mem.mem_rs_data_out;
      slot_d.cp0     = mem.mem_cp0_out;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q <= '0;
      end else if (flush) begin
         slot_q <= '0;
      end else if (!stall) begin
         slot_q <= slot_d;
      end
   end

   // A slot leaves WB on any edge that is not a plain stall; its side effects happen exactly then.
   assign retire = !stall || flush;

   // NOTE: each always_comb assigns its outputs a default first, so no path can infer a latch.
   always_comb begin
      hi_next = hi_q;
      case (slot_q.hi_sel)
         2'd0:    hi_next = slot_q.rs;
         2'd1:    hi_next = slot_q.mul_hi;
         2'd2:    hi_next = slot_q.div_r;
         default: hi_next = hi_q;
      endcase
   end

   always_comb begin
      lo_next = lo_q;
      case (slot_q.lo_sel)
         2'd0:    lo_next = slot_q.rs;
         2'd1:    lo_next = slot_q.mul_lo;
         2'd2:    lo_next = slot_q.div_q;
         default: lo_next = lo_q;
      endcase
   end

   // NOTE: this stage holds only a handful of registers (no RAM), so all of them take the async reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q  <= '0;
         lo_q  <= '0;
         cnt_q <= '0;
      end else if (retire && slot_q.valid) begin
         if (slot_q.hi_wena) hi_q <= hi_next;
         if (slot_q.lo_wena) lo_q <= lo_next;
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   // Sel 4/5 read the registered HI/LO, i.e. the value before this slot's own HI/LO write.
   always_comb begin
      rf_wdata = slot_q.alu;
      case (slot_q.rf_sel)
         3'd0: rf_wdata = slot_q.alu;
         3'd1: rf_wdata = slot_q.dmem;
         3'd2: rf_wdata = slot_q.pc4;
         3'd3: rf_wdata = slot_q.clz;
         3'd4: rf_wdata = hi_q;
         3'd5: rf_wdata = lo_q;
         3'd6: rf_wdata = slot_q.cp0;
         3'd7: rf_wdata = slot_q.mul_lo;
      endcase
   end

   assign rf_wena  = slot_q.valid & slot_q.rf_wena & (slot_q.waddr != 5'd0);
   assign rf_waddr = slot_q.waddr;
   assign hi_out   = hi_q;
   assign lo_out   = lo_q;
   assign hi_fwd   = (slot_q.valid & slot_q.hi_wena) ? hi_next : hi_q;
   assign lo_fwd   = (slot_q.valid & slot_q.lo_wena) ? lo_next : lo_q;
   assign wb_valid = slot_q.valid;
   assign instret  = cnt_q;

endmodule
